// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant stepping, GF(2^8) helpers and the expander state enum.
// Latency: none (package only).
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES_NK = 4;
    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rcon_next(input logic [7:0] rcon);
        return xtime(rcon);
    endfunction

    // Undo xtime: an odd value means the reduction polynomial was folded in.
    function automatic logic [7:0] rcon_prev(input logic [7:0] rcon);
        return rcon[0] ? (((rcon ^ 8'h1b) >> 1) | 8'h80) : (rcon >> 1);
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse AES-128 key-expansion step: round-r key back to round-(r-1) key.
// Latency: combinational.
// Backpressure: none.
// Ports: key_in = round-r key, rcon_in = rcon that produced it, key_prev_out = round-(r-1) key, rcon_prev_out = previous rcon.
module aes_inv_key_step (
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    output logic [127:0] key_prev_out,
    output logic [7:0]   rcon_prev_out
);
    import aes_pkg::*;

    logic [31:0] w4, w5, w6, w7;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;

    assign {w4, w5, w6, w7} = key_in;

    // The upper three words fall out of the XOR chain; w0 needs w3 recovered first.
    assign p3  = w7 ^ w6;
    assign p2  = w6 ^ w5;
    assign p1  = w5 ^ w4;
    assign rot = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.value(rot[8*i +: 8]), .subst(sub[8*i +: 8]));
    end

    assign p0            = w4 ^ sub ^ {rcon_in, 24'h000000};
    assign key_prev_out  = {p0, p1, p2, p3};
    assign rcon_prev_out = rcon_prev(rcon_in);

endmodule

// File: rtl/aes_key_scheduling.sv
// One forward AES-128 key-expansion step: round-r key to round-(r+1) key.
// Latency: combinational.
// Backpressure: none.
// Ports: key_in = current round key (w0 in [127:96]), rcon_in = round constant, key_next_out = next round key.
module aes_key_scheduling (
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    output logic [127:0] key_next_out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_in;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.value(rot[8*i +: 8]), .subst(sub[8*i +: 8]));
    end

    assign n0 = w0 ^ sub ^ {rcon_in, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_next_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box computed as GF(2^8) inverse followed by the affine map.
// Latency: combinational.
// Backpressure: none.
// Ports: value = input byte, subst = substituted byte.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);
    import aes_pkg::*;

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 == x^-1 (and 0 maps to 0): accumulate x^2 * x^4 * ... * x^128.
    always_comb begin
        sq  = value;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_inv_key_expander.sv
// Expands a cipher key forward to the last round key, then streams round keys last-to-first.
// Latency: key accepted in cycle T -> first round key valid in cycle T+NUM_ROUNDS+1.
// Backpressure: rk_ready_in low holds the presented round key; key_ready_out low until streaming ends.
// Ports: key_valid_in/key_ready_out/key_in = cipher key input; rk_valid_out/rk_ready_in/rk_out/
//        rk_round_out/rk_last_out = round-key stream; flush_in = synchronous abort to IDLE.
module aes_inv_key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid_in,
    output logic         key_ready_out,
    input  logic [127:0] key_in,
    output logic         rk_valid_out,
    input  logic         rk_ready_in,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round_out,
    output logic         rk_last_out,
    input  logic         flush_in
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_FWD = 4'(NUM_ROUNDS - 1);

    state_t       state;
    logic [127:0] key_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   round_cnt;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;
    logic [7:0]   rcon_inv;

    aes_key_scheduling u_fwd (
        .key_in       (key_reg),
        .rcon_in      (rcon_reg),
        .key_next_out (key_fwd)
    );

    aes_inv_key_step u_inv (
        .key_in        (key_reg),
        .rcon_in       (rcon_reg),
        .key_prev_out  (key_inv),
        .rcon_prev_out (rcon_inv)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign key_ready_out = rst_n && (state == IDLE);
    // The working key and round counter are the presented round key in EMIT.
    assign rk_out        = key_reg;
    assign rk_round_out  = round_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            key_reg      <= '0;
            rcon_reg     <= 8'h00;
            round_cnt    <= 4'd0;
            rk_valid_out <= 1'b0;
            rk_last_out  <= 1'b0;
        end else if (flush_in) begin
            state        <= IDLE;
            rk_valid_out <= 1'b0;
            rk_last_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid_in) begin
                        key_reg   <= key_in;
                        rcon_reg  <= 8'h01;
                        round_cnt <= 4'd0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_reg   <= key_fwd;
                    round_cnt <= round_cnt + 4'd1;
                    if (round_cnt == LAST_FWD) begin
                        // Keep the final rcon: it is the first one the inverse step needs.
                        state        <= EMIT;
                        rk_valid_out <= 1'b1;
                        rk_last_out  <= 1'b0;
                    end else begin
                        rcon_reg <= rcon_next(rcon_reg);
                    end
                end
                EMIT: begin
                    if (rk_ready_in) begin
                        if (round_cnt == 4'd0) begin
                            state        <= IDLE;
                            rk_valid_out <= 1'b0;
                            rk_last_out  <= 1'b0;
                        end else begin
                            key_reg     <= key_inv;
                            rcon_reg    <= rcon_inv;
                            round_cnt   <= round_cnt - 4'd1;
                            rk_last_out <= (round_cnt == 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
